// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory-slave FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } slave_state_t;

endpackage

// File: rtl/ahb_strobe_gen.sv
// Byte-lane strobes and alignment flag for an AHB transfer of size hsize at lane addr_lsb.
module ahb_strobe_gen
  import ahb_pkg::*;
#(
  parameter int unsigned dataWidth = 32
) (
  input  logic [2:0]                       hsize,
  input  logic [$clog2(dataWidth/8)-1:0]   addr_lsb,
  output logic [dataWidth/8-1:0]           strb,
  output logic                             misalign
);

  localparam int unsigned NB = dataWidth / 8;

  always_comb begin
    int unsigned nbytes;
    int unsigned lane;
    nbytes   = 32'd1 << hsize;
    lane     = 32'(addr_lsb);
    misalign = (lane & (nbytes - 32'd1)) != 32'd0;
    strb     = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      strb[i] = (i >= lane) && (i < lane + nbytes);
    end
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite RAM target: sized byte-lane writes, programmable wait states,
// two-cycle ERROR response and write-to-read forwarding.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned addrWidth  = 12,
  parameter int unsigned dataWidth  = 32,
  parameter int unsigned memDepth   = 1024,
  parameter int unsigned waitStates = 0
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hselx,
  input  logic                 hready,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hsize,
  input  logic [dataWidth-1:0] hwdata,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [dataWidth-1:0] hrdata
);

  localparam int unsigned NB    = dataWidth / 8;
  localparam int unsigned LSBW  = $clog2(NB);
  localparam int unsigned IW    = addrWidth - LSBW;
  localparam int unsigned IDXW  = (memDepth > 1) ? $clog2(memDepth) : 1;
  localparam int unsigned MAXSZ = $clog2(NB);

  logic [dataWidth-1:0] mem [memDepth];

  slave_state_t    state;
  logic [3:0]      wait_cnt;
  logic            d_valid;
  logic            d_write;
  logic [IDXW-1:0] d_idx;
  logic [NB-1:0]   d_strb;

  logic                 accept;
  logic                 req_err;
  logic                 misalign;
  logic                 commit;
  logic [IW-1:0]        req_idx;
  logic [NB-1:0]        req_strb;
  logic [dataWidth-1:0] wmask;
  logic [dataWidth-1:0] rd_word;
  logic [dataWidth-1:0] fwd_word;

  ahb_strobe_gen #(.dataWidth(dataWidth)) u_strb (
    .hsize    (hsize),
    .addr_lsb (haddr[LSBW-1:0]),
    .strb     (req_strb),
    .misalign (misalign)
  );

  assign accept  = ((state == S_IDLE) || (state == S_ERR2)) && hselx && hready &&
                   ((htrans == NONSEQ) || (htrans == SEQ));
  assign req_idx = haddr[addrWidth-1:LSBW];
  assign req_err = (32'(req_idx) >= memDepth) || (hsize > 3'(MAXSZ)) || misalign;

  // The last cycle of an OKAY data phase is always spent in S_IDLE.
  assign commit  = d_valid && d_write && (state == S_IDLE);

  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      wmask[8*i +: 8] = {8{d_strb[i]}};
    end
  end

  // Read accepted on the edge a same-word write commits sees the merged word.
  assign rd_word  = mem[req_idx[IDXW-1:0]];
  assign fwd_word = (commit && (d_idx == req_idx[IDXW-1:0])) ?
                    ((hwdata & wmask) | (rd_word & ~wmask)) : rd_word;

  assign hreadyout = !((state == S_WAIT) || (state == S_ERR1));
  assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (d_strb[i]) mem[d_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      d_valid  <= 1'b0;
      d_write  <= 1'b0;
      d_idx    <= '0;
      d_strb   <= '0;
      hrdata   <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            if (!d_write) hrdata <= mem[d_idx];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: state <= S_ERR2;
        default: begin
          if (accept && req_err) begin
            state   <= S_ERR1;
            d_valid <= 1'b0;
            hrdata  <= '0;
          end else if (accept) begin
            d_valid <= 1'b1;
            d_write <= hwrite;
            d_idx   <= req_idx[IDXW-1:0];
            d_strb  <= req_strb;
            if (waitStates == 0) begin
              state <= S_IDLE;
              if (!hwrite) hrdata <= fwd_word;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(waitStates);
            end
          end else begin
            state   <= S_IDLE;
            d_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: zero-wait and three-wait instances on a shared bus.
module tb_ahb_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel3;
  logic [12:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        ro0, rp0, ro3, rp3;
  logic [31:0] rd0, rd3;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 hclk = ~hclk;

  ahb_mem_slave #(.addrWidth(13), .dataWidth(32), .memDepth(1024), .waitStates(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel0), .hready(ro0), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hwdata(hwdata),
    .hreadyout(ro0), .hresp(rp0), .hrdata(rd0));

  ahb_mem_slave #(.addrWidth(13), .dataWidth(32), .memDepth(1024), .waitStates(3)) dut3 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel3), .hready(ro3), .haddr(haddr),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hwdata(hwdata),
    .hreadyout(ro3), .hresp(rp3), .hrdata(rd3));

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        v;
    logic        wr;
    logic [12:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } rt_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic sel3, input logic wr, input logic [12:0] a, input logic [2:0] sz);
    hsel0 = !sel3; hsel3 = sel3; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic do_txn0(input vec_t v, input int idx);
    addr_phase(1'b0, v.wr, v.addr, v.size);
    tick();
    bus_idle();
    hwdata = v.wdata;
    @(negedge hclk);
    if (v.err) begin
      check($sformatf("vec%0d_err1_ready", idx), 32'(ro0), 32'd0);
      check($sformatf("vec%0d_err1_resp", idx), 32'(rp0), 32'd1);
      check($sformatf("vec%0d_err1_rdata", idx), rd0, 32'd0);
      tick();
      @(negedge hclk);
      check($sformatf("vec%0d_err2_ready", idx), 32'(ro0), 32'd1);
      check($sformatf("vec%0d_err2_resp", idx), 32'(rp0), 32'd1);
    end else begin
      check($sformatf("vec%0d_ready", idx), 32'(ro0), 32'd1);
      check($sformatf("vec%0d_resp", idx), 32'(rp0), 32'd0);
      if (!v.wr) check($sformatf("vec%0d_rdata", idx), rd0, v.rdata);
    end
    tick();
  endtask

  // Full ws=3 read: counts low-ready cycles with a bound, then checks data.
  task automatic read3(input logic [12:0] a, input logic [31:0] exp, input string name);
    int unsigned lows;
    addr_phase(1'b1, 1'b0, a, 3'b010);
    tick();
    bus_idle();
    lows = 0;
    @(negedge hclk);
    while (!ro3 && lows < 10) begin
      lows++;
      tick();
      @(negedge hclk);
    end
    check({name, "_lows"}, lows, 32'd3);
    check({name, "_resp"}, 32'(rp3), 32'd0);
    check({name, "_rdata"}, rd3, exp);
    tick();
  endtask

  vec_t vecs[13];
  logic [7:0] mb [64];
  localparam int NR = 400;

  initial begin
    rt_t cur, prev;
    int unsigned w, sz, off, lows;

    vecs[0]  = '{1'b1, 13'h010, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 13'h010, 3'b010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 13'h010, 3'b010, 32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 13'h013, 3'b000, 32'hAA000000, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 13'h010, 3'b010, 32'h0,        1'b0, 32'hAA223344};
    vecs[5]  = '{1'b1, 13'h011, 3'b001, 32'h55555555, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 13'h010, 3'b010, 32'h0,        1'b0, 32'hAA223344};
    vecs[7]  = '{1'b0, 13'h1000, 3'b010, 32'h0,       1'b1, 32'h0};
    vecs[8]  = '{1'b1, 13'h014, 3'b010, 32'h00000000, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 13'h016, 3'b001, 32'hBEEF1234, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 13'h014, 3'b010, 32'h0,        1'b0, 32'hBEEF0000};
    vecs[11] = '{1'b1, 13'h018, 3'b011, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 13'h01A, 3'b010, 32'hFFFFFFFF, 1'b1, 32'h0};

    hresetn = 1'b0;
    bus_idle();
    haddr = '0; hsize = 3'b010; hwdata = '0;
    @(negedge hclk);
    check("rst_ready0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(rp0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_ready3", 32'(ro3), 32'd1);
    tick();
    hresetn = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) do_txn0(vecs[i], i);

    // Error, then a valid read accepted in the ERR2 cycle.
    addr_phase(1'b0, 1'b0, 13'h1000, 3'b010);
    tick();
    addr_phase(1'b0, 1'b0, 13'h010, 3'b010);
    @(negedge hclk);
    check("oor_err1_ready", 32'(ro0), 32'd0);
    check("oor_err1_resp", 32'(rp0), 32'd1);
    tick();
    @(negedge hclk);
    check("oor_err2_ready", 32'(ro0), 32'd1);
    check("oor_err2_resp", 32'(rp0), 32'd1);
    check("oor_err2_rdata", rd0, 32'd0);
    tick();
    bus_idle();
    @(negedge hclk);
    check("after_err_resp", 32'(rp0), 32'd0);
    check("after_err_rdata", rd0, 32'hAA223344);
    tick();

    // Pipelined write then read of the same word.
    addr_phase(1'b0, 1'b1, 13'h020, 3'b010);
    tick();
    addr_phase(1'b0, 1'b0, 13'h020, 3'b010);
    hwdata = 32'h12345678;
    @(negedge hclk);
    check("fwd_wr_ready", 32'(ro0), 32'd1);
    tick();
    bus_idle();
    hwdata = 32'h0;
    @(negedge hclk);
    check("fwd_rdata", rd0, 32'h12345678);
    tick();

    // Randomized pipelined traffic on words 0x100..0x13C against a byte-array model.
    prev = '{default: '0};
    for (int c = 0; c <= NR; c++) begin
      cur = '{default: '0};
      if (c < NR) begin
        if (c < 16) begin
          w = 32'(c); sz = 2; off = 0; cur.v = 1'b1; cur.wr = 1'b1;
        end else begin
          w = $urandom_range(15); sz = $urandom_range(2);
          off = $urandom_range(3) & ~((32'd1 << sz) - 32'd1);
          cur.v = ($urandom_range(3) != 0); cur.wr = $urandom_range(1) != 0;
        end
        cur.size = 3'(sz);
        cur.addr = 13'(32'h100 + w * 4 + off);
        cur.wdata = $urandom;
        if (cur.v && cur.wr) begin
          for (int unsigned b = 0; b < (32'd1 << sz); b++)
            mb[w*4 + off + b] = cur.wdata[8*(off+b) +: 8];
        end else if (cur.v) begin
          cur.exp = {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
        end
      end
      if (cur.v) begin
        addr_phase(1'b0, cur.wr, cur.addr, cur.size);
        htrans = ($urandom_range(1) != 0) ? 2'b11 : 2'b10;
      end else begin
        hsel0 = $urandom_range(1) != 0;
        htrans = hsel0 ? 2'($urandom_range(1)) : 2'($urandom_range(3));
        hwrite = $urandom_range(1) != 0;
        haddr = cur.addr; hsize = cur.size;
      end
      hwdata = (prev.v && prev.wr) ? prev.wdata : $urandom;
      @(negedge hclk);
      check("rnd_ready", 32'(ro0), 32'd1);
      check("rnd_resp", 32'(rp0), 32'd0);
      if (prev.v && !prev.wr) check($sformatf("rnd_rdata_%0d", c), rd0, prev.exp);
      tick();
      prev = cur;
    end
    bus_idle();
    tick();

    // Three wait states: write, then read with a held address that must not be taken.
    addr_phase(1'b1, 1'b1, 13'h030, 3'b010);
    tick();
    bus_idle();
    hwdata = 32'hCAFEF00D;
    lows = 0;
    @(negedge hclk);
    while (!ro3 && lows < 10) begin lows++; tick(); @(negedge hclk); end
    check("ws3_wr_lows", lows, 32'd3);
    tick();

    addr_phase(1'b1, 1'b0, 13'h030, 3'b010);
    tick();
    hwrite = 1'b1;
    hwdata = 32'hBAD0BAD0;
    lows = 0;
    @(negedge hclk);
    while (!ro3 && lows < 10) begin
      lows++;
      check("ws3_rdata_hold", rd3, 32'd0);
      tick();
      @(negedge hclk);
    end
    bus_idle();
    check("ws3_rd_lows", lows, 32'd3);
    check("ws3_rd_rdata", rd3, 32'hCAFEF00D);
    tick();
    @(negedge hclk);
    check("ws3_no_extra_accept", 32'(ro3), 32'd1);
    tick();
    read3(13'h030, 32'hCAFEF00D, "ws3_reread");

    // Errors take two cycles even with wait states configured.
    addr_phase(1'b1, 1'b0, 13'h1000, 3'b010);
    tick();
    bus_idle();
    @(negedge hclk);
    check("ws3_err1", {30'd0, ro3, rp3}, 32'b01);
    tick();
    @(negedge hclk);
    check("ws3_err2", {30'd0, ro3, rp3}, 32'b11);
    check("ws3_err_rdata", rd3, 32'd0);
    tick();
    read3(13'h030, 32'hCAFEF00D, "ws3_after_err");

    // Asynchronous reset during the wait phase of a write.
    addr_phase(1'b1, 1'b1, 13'h030, 3'b010);
    tick();
    bus_idle();
    hwdata = 32'h55555555;
    @(negedge hclk);
    check("rst_mid_wait_low", 32'(ro3), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    check("rst_async_ready", 32'(ro3), 32'd1);
    check("rst_async_resp", 32'(rp3), 32'd0);
    check("rst_async_rdata", rd3, 32'd0);
    tick();
    tick();
    hresetn = 1'b1;
    tick();
    read3(13'h030, 32'hCAFEF00D, "rst_word_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
